muldiv_exec: RTL
================

// Module: muldiv_exec
// PURPOSE
//  Multi-cycle RV32M/RV64M multiply/divide execution unit beside the integer ALU in the X stage.
//  Accepts one OP/funct7=0000001 instruction per transaction and iterates BITS_PER_CYCLE bits per clock.
//  Returns rd and rd_data through a valid/ready response channel.
//  Drives busy_o so the pipeline holds its hazard stall while an operation is in flight.
// PARAMETERS
//  XLEN            32  operand/result width; 32 or 64
//  BITS_PER_CYCLE  1   quotient/multiplier bits retired per iteration; 1, 2 or 4; must divide XLEN
// PORTS
//  clk          in   1     clock, rising edge
//  reset_n      in   1     asynchronous, active-low reset
//  req_v_i      in   1     request valid
//  req_rdy_o    out  1     request ready; high only in IDLE
//  funct3_i     in   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  rd_i         in   5     destination register
//  rs1_data_i   in   XLEN  operand a (multiplicand/dividend)
//  rs2_data_i   in   XLEN  operand b (multiplier/divisor)
//  flush_i      in   1     kill in-flight operation (branch redirect)
//  busy_o       out  1     state != IDLE
//  rsp_v_o      out  1     result valid
//  rsp_rdy_i    in   1     result consumed
//  rd_o         out  5     destination register of result
//  rd_data_o    out  XLEN  result
// BEHAVIOUR
//  Reset: state=IDLE; rsp_v_o=0, busy_o=0, rd_o=0, rd_data_o=0; req_rdy_o=1 after reset release.
//  Reset is async: outputs clear immediately, including mid-BUSY or mid-DONE.
//  FSM IDLE->BUSY->FIX->DONE->IDLE.
//  Accept = req_v_i & req_rdy_o at edge t0. Latch funct3, rd, |a|, |b| and the result sign.
//   Signedness: MULH/DIV/REM both operands signed; MULHSU a only; others unsigned.
//  BUSY: STEPS = XLEN/BITS_PER_CYCLE iterations, counter down to 0.
//   mul: shift-add into a 2*XLEN accumulator.
//   div: restoring shift-subtract; quotient and remainder registers XLEN wide.
//  FIX: one cycle. Apply two's-complement sign correction, then select the result:
//   low half (MUL), high half (MULH*), quotient, or remainder.
//   Remainder takes the dividend sign; quotient is negative when operand signs differ.
//  DONE: rsp_v_o=1 with rd_o/rd_data_o stable until rsp_rdy_i. Leave for IDLE on the rsp_v_o&rsp_rdy_i edge.
//  Latency: STEPS+2 edges from accept to rsp_v_o high (34 for XLEN=32, BPC=1).
//  Throughput: one bubble minimum between ops; req_rdy_o is low in DONE.
//  Early-out cases skip BUSY/FIX; IDLE->DONE at t0+1, latency 1:
//   b==0: DIV/DIVU -> all ones; REM/REMU -> a.
//   signed overflow (a=MIN_INT, b=-1): DIV -> MIN_INT; REM -> 0.
//  flush_i: any state -> IDLE at next edge.
//   rsp_v_o drops, no result is delivered, and a request presented in the same cycle is not accepted.
//   flush_i and rsp_rdy_i together in DONE: flush wins, same as a normal handshake.
//  req_v_i while not IDLE is ignored; the requester holds req_v_i.
//  Counter width is $clog2(STEPS+1). No wrap is possible: the counter reloads only on accept.
// CONFIGURATION
//  MDU_FAST_MUL_EN defined:
//   MUL/MULH/MULHSU/MULHU use a single XLEN+1 x XLEN+1 signed product registered at t0+1.
//   Path is IDLE->DONE with latency 1. Division is unchanged.
//  Not defined: all multiplies use the iterative BUSY/FIX path with latency STEPS+2.
//  funct3, handshake and result values are identical in both builds.
// TESTING
//  1 MUL 7*0xFFFFFFFD -> rd_data 0xFFFFFFEB.
//    rsp_v_o exactly 34 cycles after accept; 1 cycle with MDU_FAST_MUL_EN.
//  2 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//    MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
//  3 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  4 DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
//    All four latency 1.
//  5 rsp_rdy_i low for 10 cycles in DONE -> rsp_v_o, rd_o, rd_data_o stable and req_rdy_o=0.
//    Handshake edge -> IDLE; next request accepted one cycle later.
//  6 flush_i at BUSY iteration 5 -> IDLE next cycle with busy_o=0 and no rsp_v_o.
//    reset_n low mid-BUSY -> all outputs at reset values without a clock edge.
//    Rerun after release -> correct result.

Source files
------------

// File: rtl/muldiv_exec.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready response.
// MDU_FAST_MUL_EN selects a single-cycle multiplier; divides stay iterative.
module muldiv_exec #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_v_i,
  output logic            req_rdy_o,
  input  logic [2:0]      funct3_i,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            rsp_v_o,
  input  logic            rsp_rdy_i,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] rd_data_o
);

  localparam int STEPS = XLEN / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(STEPS);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);
  localparam logic [XLEN-1:0] MIN_INT =
    {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]        r_f3;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;
  logic              r_neg;
  logic              r_neg_a;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_rd_data;

  logic              w_accept;
  logic              w_is_div;
  logic              w_sgn_a;
  logic              w_sgn_b;
  logic              w_neg_a;
  logic              w_neg_b;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic              w_div0;
  logic              w_ovf;
  logic              w_early;
  logic [XLEN-1:0]   w_early_res;
  logic              w_fast;

  logic [2*XLEN-1:0] w_step;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_diff;
  logic [XLEN:0]     w_sum;

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_res;

  // Request decode: operand signedness, magnitudes, early-out cases
  always_comb begin
    w_accept = (r_state == S_IDLE) & req_v_i & ~flush_i;
    w_is_div = funct3_i[2];
    w_sgn_a  = (funct3_i == 3'b001) | (funct3_i == 3'b010) |
               (funct3_i == 3'b100) | (funct3_i == 3'b110);
    w_sgn_b  = (funct3_i == 3'b001) | (funct3_i == 3'b100) |
               (funct3_i == 3'b110);
    w_neg_a  = w_sgn_a & rs1_data_i[XLEN-1];
    w_neg_b  = w_sgn_b & rs2_data_i[XLEN-1];
    w_abs_a  = w_neg_a ? -rs1_data_i : rs1_data_i;
    w_abs_b  = w_neg_b ? -rs2_data_i : rs2_data_i;
    w_div0   = w_is_div & (rs2_data_i == '0);
    w_ovf    = w_is_div & ~funct3_i[0] &
               (rs1_data_i == MIN_INT) & (rs2_data_i == '1);
    w_early  = w_div0 | w_ovf;
    w_early_res = '0;
    if (w_div0)
      w_early_res = funct3_i[1] ? rs1_data_i : '1;
    else if (w_ovf)
      w_early_res = funct3_i[1] ? '0 : MIN_INT;
  end

`ifdef MDU_FAST_MUL_EN
  logic signed [2*XLEN-1:0] w_fa;
  logic signed [2*XLEN-1:0] w_fb;
  logic signed [2*XLEN-1:0] w_fprod;
  logic [XLEN-1:0]          w_fast_res;

  // Single-cycle signed product of sign/zero-extended operands
  always_comb begin
    w_fast = ~funct3_i[2];
    w_fa = {{XLEN{w_sgn_a & rs1_data_i[XLEN-1]}}, rs1_data_i};
    w_fb = {{XLEN{w_sgn_b & rs2_data_i[XLEN-1]}}, rs2_data_i};
    w_fprod = w_fa * w_fb;
    w_fast_res = (funct3_i[1:0] == 2'b00) ?
                 w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
  end
`else
  assign w_fast = 1'b0;
`endif

  // One BUSY iteration: BITS_PER_CYCLE shift-add or shift-subtract steps
  always_comb begin
    w_step   = r_acc;
    w_rem_sh = '0;
    w_diff   = '0;
    w_sum    = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_f3[2]) begin
        w_rem_sh = {w_step[2*XLEN-1:XLEN], w_step[XLEN-1]};
        w_diff   = w_rem_sh - {1'b0, r_b};
        if (!w_diff[XLEN])
          w_step = {w_diff[XLEN-1:0], w_step[XLEN-2:0], 1'b1};
        else
          w_step = {w_rem_sh[XLEN-1:0], w_step[XLEN-2:0], 1'b0};
      end else begin
        w_sum = {1'b0, w_step[2*XLEN-1:XLEN]};
        if (w_step[0])
          w_sum = w_sum + {1'b0, r_a};
        w_step = {w_sum, w_step[XLEN-1:1]};
      end
    end
  end

  // Sign correction and result selection for the FIX cycle
  always_comb begin
    w_prod = r_neg ? -r_acc : r_acc;
    w_quo  = r_neg ? -(r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
    w_rem  = r_neg_a ? -(r_acc[2*XLEN-1:XLEN]) :
                       r_acc[2*XLEN-1:XLEN];
    w_fix_res = w_prod[XLEN-1:0];
    unique case (1'b1)
      r_f3[2] & r_f3[1]:
        w_fix_res = w_rem;
      r_f3[2] & ~r_f3[1]:
        w_fix_res = w_quo;
      ~r_f3[2] & (r_f3[1:0] != 2'b00):
        w_fix_res = w_prod[2*XLEN-1:XLEN];
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state logic; flush returns to IDLE from anywhere
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_accept)
          w_next = (w_early | w_fast) ? S_DONE : S_BUSY;
      S_BUSY:
        if (flush_i)
          w_next = S_IDLE;
        else if (r_cnt == CNT_LAST)
          w_next = S_FIX;
      S_FIX:
        w_next = flush_i ? S_IDLE : S_DONE;
      S_DONE:
        if (flush_i | rsp_rdy_i)
          w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  // Output decode from state and result registers
  always_comb begin
    req_rdy_o = (r_state == S_IDLE);
    busy_o    = (r_state != S_IDLE);
    rsp_v_o   = (r_state == S_DONE);
    rd_o      = r_rd;
    rd_data_o = r_rd_data;
  end

  // Datapath: operand latch on accept, iteration, result capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_f3      <= '0;
      r_rd      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_neg     <= 1'b0;
      r_neg_a   <= 1'b0;
      r_cnt     <= '0;
      r_rd_data <= '0;
    end else if (w_accept) begin
      r_f3    <= funct3_i;
      r_rd    <= rd_i;
      r_a     <= w_abs_a;
      r_b     <= w_abs_b;
      r_acc   <= {{XLEN{1'b0}}, w_is_div ? w_abs_a : w_abs_b};
      r_neg   <= w_neg_a ^ w_neg_b;
      r_neg_a <= w_neg_a;
      r_cnt   <= CNT_LOAD;
      if (w_early)
        r_rd_data <= w_early_res;
`ifdef MDU_FAST_MUL_EN
      else if (w_fast)
        r_rd_data <= w_fast_res;
`endif
    end else if (r_state == S_BUSY) begin
      r_acc <= w_step;
      r_cnt <= r_cnt - 1'b1;
    end else if (r_state == S_FIX) begin
      r_rd_data <= w_fix_res;
    end
  end

endmodule
